alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Multi-cycle operation sequencer for the UART ALU datapath. It accepts one command (opcode plus two signed N-bit operands) over a valid/ready handshake and computes ADD, SUB or the low-N-bit MUL. All arithmetic runs through exactly one internal instance of the team's `cla_adder`, which is N-bit with carry-in fixed to 0 and reports flags {V,N,Z,P}. The sequencer orders the adder passes, holds the registered result and flags until the downstream UART response path takes them, and sits between the command decoder and the response formatter.

## Interface
- `N`, default 16: operand/result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  sequencer can accept; = (state==IDLE) & rst_n.
- `op`  in  2  00 ADD, 01 SUB (a−b), 10 MUL (low N bits of a×b), 11 reserved.
- `a`, `b`  in  N each  signed operands; sampled only on the accept edge.
- `out_valid`  out  1  result/flags/err valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  N  registered result.
- `flags`  out  4  registered {V,N,Z,P}; P = even parity of `result`.
- `err`  out  1  reserved opcode was accepted.

## Operation
- Accept: `in_valid & in_ready` at a rising edge. On that edge, capture `op`, `a` and `b` into internal registers. The inputs may change afterwards.
- States: IDLE, NEG, ADD, MUL, DONE. Every state except IDLE/DONE lasts one cycle per step.
- Transitions on accept from IDLE:
  - ADD → state ADD.
  - SUB → state NEG.
  - MUL → state MUL.
  - reserved → state DONE directly, with result 0, flags 0 and err 1.
- ADD state: adder inputs are (opA, opB). On the exit edge, register the adder sum and adder flags and go to DONE.
- NEG state (SUB pass 1): adder computes tmp = ~b + 1, with inputs (~b, 1). Store tmp and go to ADD with opB = tmp.
- SUB final pass: `result` is the adder sum. N, Z and P come from the adder. V is recomputed as (a[N-1]^b[N-1]) & (result[N-1]^a[N-1]), using the original b. This gives correct overflow for b = −2^(N-1).
- MUL state: N iterations, i = 0..N-1, one cycle each.
  - Initial values: acc = 0, mcand = a, mplier = b.
  - Each iteration: if mplier[i] is set, acc ← adder(acc, mcand); otherwise acc is unchanged. Then mcand ← mcand<<1.
  - Use a log2(N)-bit iteration counter; at i = N-1, register acc and go to DONE.
  - MUL flags: V = 0; N, Z and P are computed from the final acc.
- DONE: `out_valid` = 1. `result`, `flags` and `err` are held stable while `out_ready` = 0.
- Leaving DONE: `out_valid & out_ready` → IDLE, and `err` clears on that edge. `in_ready` is 0 in DONE, so no accept can happen in the same cycle.
- Wrap-around: adder sums are taken modulo 2^N. The MUL high half is discarded.

## Timing
- Latency is counted in rising edges from the accept edge (inclusive) to the edge after which `out_valid` = 1:
  - ADD: 2.
  - SUB: 3.
  - MUL: N+1 (17 for N = 16).
  - reserved: 1.
- Throughput: one command per (latency + 1) cycles minimum, because of the mandatory return to IDLE.
- The adder is purely combinational inside a single cycle. No other combinational path runs from `a`/`b` to any output.
- Reset: when `rst_n` = 0 at an edge, the following hold after that edge, regardless of state (including mid-SUB or mid-MUL):
  - state = IDLE;
  - `out_valid` = 0, `result` = 0, `flags` = 0, `err` = 0;
  - the iteration counter and acc are 0.
- The in-flight command is discarded; no partial result is ever presented.
- `in_ready` = 0 while `rst_n` = 0, and `in_ready` = 1 in the first cycle after reset is released.
- `in_valid` asserted outside IDLE is ignored and is not queued.

## Test plan
1. ADD a=0x7FFF, b=0x0001 → result 0x8000, flags 4'b1100; `out_valid` after 2 edges.
2. SUB a=0x0005, b=0x0005 → 0x0000, flags 4'b0011, latency 3. Then SUB a=0x0000, b=0x8000 → 0x8000, flags 4'b1100.
3. MUL a=0xFFFD (−3), b=0x0007 → 0xFFEB, flags 4'b0101; latency 17 edges.
4. ADD 0x1234+0x0001 with `out_ready` held low 5 cycles:
   - result 0x1235 stays stable, `in_ready` stays 0, and a second `in_valid` pulse is ignored;
   - on `out_ready`=1, return to IDLE after exactly 1 edge, and exactly one result is observed.
5. Assert `rst_n` low at MUL iteration 8 for 1 cycle:
   - all outputs are 0 and `in_ready` = 1 after release;
   - then ADD 1+2 → 0x0003, flags 4'b0001.
6. op=11, a=0x1111, b=0x2222 → after 1 edge `out_valid`=1, `err`=1, result 0x0000, flags 4'b0000. `err` clears on the handshake edge.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL sequencer. Every arithmetic pass goes through one shared cla_adder.
// Results are held in registers until the response path takes them over out_valid/out_ready.

module cla_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic [3:0]   flags
);
  logic [N-1:0] g, p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum   = p ^ c[N-1:0];
  // {V,N,Z,P}: P is 1 when the sum holds an even number of ones.
  assign flags = {c[N] ^ c[N-1], sum[N-1], ~|sum, ~^sum};
endmodule

module alu_op_sequencer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         err
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_NEG, S_ADD, S_MUL, S_DONE} state_t;

  state_t         state, state_nx;
  logic [1:0]     op_r;
  logic [N-1:0]   opa, opb, acc, acc_nx;
  logic           b_msb;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   add_a, add_b, sum;
  logic [3:0]     add_fl;
  logic           accept, mul_last, sub_v;

  cla_adder #(.N(N)) u_add (
    .a     (add_a),
    .b     (add_b),
    .cin   (1'b0),
    .sum   (sum),
    .flags (add_fl)
  );

  assign accept   = in_valid & in_ready;
  assign mul_last = (cnt == CW'(N-1));
  assign acc_nx   = opb[cnt] ? sum : acc;
  // Overflow judged against the original subtrahend, so b = -2^(N-1) is handled.
  assign sub_v    = (opa[N-1] ^ b_msb) & (sum[N-1] ^ opa[N-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        if (accept) begin
          case (op)
            2'b00:   state_nx = S_ADD;
            2'b01:   state_nx = S_NEG;
            2'b10:   state_nx = S_MUL;
            default: state_nx = S_DONE;
          endcase
        end
      end
      S_NEG: begin
        add_a    = ~opb;
        add_b    = N'(1);
        state_nx = S_ADD;
      end
      S_ADD: begin
        add_a    = opa;
        add_b    = opb;
        state_nx = S_DONE;
      end
      S_MUL: begin
        add_a = acc;
        add_b = opa;
        if (mul_last) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r   <= '0;
      opa    <= '0;
      opb    <= '0;
      b_msb  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_r  <= op;
          opa   <= a;
          opb   <= b;
          b_msb <= b[N-1];
          acc   <= '0;
          cnt   <= '0;
          err   <= (op == 2'b11);
          if (op == 2'b11) begin
            result <= '0;
            flags  <= '0;
          end
        end
        S_NEG: opb <= sum;
        S_ADD: begin
          result <= sum;
          flags  <= (op_r == 2'b01) ? {sub_v, add_fl[2:0]} : add_fl;
        end
        // Shift-and-add: opa doubles as the shifting multiplicand, opb is the multiplier.
        S_MUL: begin
          acc <= acc_nx;
          opa <= opa << 1;
          cnt <= cnt + CW'(1);
          if (mul_last) begin
            result <= acc_nx;
            flags  <= {1'b0, acc_nx[N-1], ~|acc_nx, ~^acc_nx};
          end
        end
        S_DONE: if (out_ready) err <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
